// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types for the core/SBA memory-port arbiter: requester
//               identity, bus request/response bundles and a small helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Who currently drives the memory port.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_SBA  = 2'd2
    } owner_t;

    localparam int c_BUS_ADDR_WIDTH = 32;
    localparam int c_BUS_DATA_WIDTH = 32;
    localparam int c_BUS_BE_WIDTH   = c_BUS_DATA_WIDTH / 8;

    // Request bundle as presented by a bus master (also used by the debug module).
    typedef struct packed {
        logic [c_BUS_ADDR_WIDTH-1:0] addr;
        logic [c_BUS_DATA_WIDTH-1:0] wdata;
        logic [c_BUS_BE_WIDTH-1:0]   be;
        logic                        read;
        logic                        write;
    } bus_req_t;

    // Response bundle returned to a bus master.
    typedef struct packed {
        logic [c_BUS_DATA_WIDTH-1:0] rdata;
        logic                        complete;
        logic                        error;
    } bus_rsp_t;

    // The requester that is not the given one; used to break ties.
    function automatic owner_t other_side(input owner_t who);
        return (who == OWN_CORE) ? OWN_SBA : OWN_CORE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_watchdog
// Description : Counts consecutive waiting cycles of an active transaction and
//               raises fire on the TIMEOUT-th one. TIMEOUT=0 disables it.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic done,
    output logic fire
);

    localparam int c_CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [c_CW-1:0] r_count;

    // Fire only while a transaction is actually waiting on memory.
    assign fire = (TIMEOUT != 0) && active && (r_count == c_LAST);

    // Age counter: restarts on completion, abort or idle; never passes c_LAST
    // because reaching it forces a completion.
    always_ff @(posedge clk) begin
        if (!rst_n || !active || done) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one memory port between the core sequencer and the
//               debug SBA engine. Zero-latency forwarding, grant locked for a
//               whole transaction, round-robin ties, watchdog error completion.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   core_addr,
    input  logic [DATA_WIDTH-1:0]   core_wdata,
    input  logic [DATA_WIDTH/8-1:0] core_be,
    input  logic                    core_read,
    input  logic                    core_write,
    output logic [DATA_WIDTH-1:0]   core_rdata,
    output logic                    core_complete,
    output logic                    core_error,
    input  logic [ADDR_WIDTH-1:0]   sba_addr,
    input  logic [DATA_WIDTH-1:0]   sba_wdata,
    input  logic [DATA_WIDTH/8-1:0] sba_be,
    input  logic                    sba_read,
    input  logic                    sba_write,
    output logic [DATA_WIDTH-1:0]   sba_rdata,
    output logic                    sba_complete,
    output logic                    sba_error,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic                    mem_read,
    output logic                    mem_write,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_complete,
    input  logic                    mem_error
);

    owner_t r_owner;
    owner_t r_last;
    owner_t w_sel;
    logic   w_core_req;
    logic   w_sba_req;
    logic   w_sel_req;
    logic   w_sel_rd;
    logic   w_sel_wr;
    logic   w_fire;
    logic   w_done;
    logic   w_err;

    assign w_core_req = core_read | core_write;
    assign w_sba_req  = sba_read | sba_write;

    // Pick the requester for this cycle: the locked owner, else round-robin.
    always_comb begin
        w_sel = OWN_NONE;
        if (r_owner != OWN_NONE) begin
            w_sel = r_owner;
        end else if (w_core_req && w_sba_req) begin
            w_sel = other_side(r_last);
        end else if (w_core_req) begin
            w_sel = OWN_CORE;
        end else if (w_sba_req) begin
            w_sel = OWN_SBA;
        end
    end

    // Forward the selected request to memory; write beats read on a requester.
    always_comb begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_be    = core_be;
        w_sel_req = 1'b0;
        w_sel_rd  = 1'b0;
        w_sel_wr  = 1'b0;
        if (w_sel == OWN_CORE) begin
            w_sel_req = w_core_req;
            w_sel_rd  = core_read & ~core_write;
            w_sel_wr  = core_write;
        end else if (w_sel == OWN_SBA) begin
            mem_addr  = sba_addr;
            mem_wdata = sba_wdata;
            mem_be    = sba_be;
            w_sel_req = w_sba_req;
            w_sel_rd  = sba_read & ~sba_write;
            w_sel_wr  = sba_write;
        end
    end

    // A watchdog-terminated access must not be left pending at memory.
    assign mem_read  = w_sel_rd & ~w_fire;
    assign mem_write = w_sel_wr & ~w_fire;

    // A real memory completion takes precedence over the watchdog.
    assign w_done = w_sel_req & (mem_complete | w_fire);
    assign w_err  = (mem_complete & mem_error) | (w_fire & ~mem_complete);

    assign core_complete = (w_sel == OWN_CORE) & w_done;
    assign core_error    = (w_sel == OWN_CORE) & w_done & w_err;
    assign sba_complete  = (w_sel == OWN_SBA) & w_done;
    assign sba_error     = (w_sel == OWN_SBA) & w_done & w_err;
    assign core_rdata    = mem_rdata;
    assign sba_rdata     = mem_rdata;

    // Hold the grant across wait states; release on completion or abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner <= OWN_NONE;
            r_last  <= OWN_SBA;
        end else begin
            r_owner <= (w_sel_req && !w_done) ? w_sel : OWN_NONE;
            if (w_done) begin
                r_last <= w_sel;
            end
        end
    end

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .active (w_sel_req),
        .done   (w_done),
        .fire   (w_fire)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed scenarios followed by random traffic for mem_arbiter,
//               checked every cycle against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] core_addr, sba_addr, mem_addr;
    logic [DW-1:0] core_wdata, sba_wdata, mem_wdata;
    logic [BW-1:0] core_be, sba_be, mem_be;
    logic          core_read, core_write, sba_read, sba_write;
    logic [DW-1:0] core_rdata, sba_rdata, mem_rdata;
    logic          core_complete, core_error, sba_complete, sba_error;
    logic          mem_read, mem_write, mem_complete, mem_error;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .core_be       (core_be),
        .core_read     (core_read),
        .core_write    (core_write),
        .core_rdata    (core_rdata),
        .core_complete (core_complete),
        .core_error    (core_error),
        .sba_addr      (sba_addr),
        .sba_wdata     (sba_wdata),
        .sba_be        (sba_be),
        .sba_read      (sba_read),
        .sba_write     (sba_write),
        .sba_rdata     (sba_rdata),
        .sba_complete  (sba_complete),
        .sba_error     (sba_error),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_rdata     (mem_rdata),
        .mem_complete  (mem_complete),
        .mem_error     (mem_error)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Transaction-level model: who is mid-transaction (0 none, 1 core, 2 sba),
    // how many cycles it has waited, and who finished the last transaction.
    int m_current;
    int m_waited;
    int m_turn;
    // Prediction for the current cycle.
    int e_sel;
    bit e_busy;
    bit e_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Predict this cycle from the rules and compare every output.
    task automatic check_outputs();
        bit rc, rs, timed_out, err, rd, wr;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_wdata;
        logic [BW-1:0] x_be;
        rc = core_read | core_write;
        rs = sba_read | sba_write;
        if (m_current != 0)   e_sel = m_current;
        else if (rc && rs)    e_sel = (m_turn == 1) ? 2 : 1;
        else if (rc)          e_sel = 1;
        else if (rs)          e_sel = 2;
        else                  e_sel = 0;
        e_busy    = (e_sel == 1) ? rc : (e_sel == 2) ? rs : 1'b0;
        timed_out = e_busy && (TO != 0) && (m_waited + 1 == TO);
        e_done    = e_busy && (mem_complete || timed_out);
        err       = mem_complete ? mem_error : timed_out;
        x_addr  = (e_sel == 2) ? sba_addr  : core_addr;
        x_wdata = (e_sel == 2) ? sba_wdata : core_wdata;
        x_be    = (e_sel == 2) ? sba_be    : core_be;
        wr = (e_sel == 1) ? core_write : (e_sel == 2) ? sba_write : 1'b0;
        rd = ((e_sel == 1) ? core_read : (e_sel == 2) ? sba_read : 1'b0) && !wr;
        chk("mem_addr",      mem_addr,      x_addr);
        chk("mem_wdata",     mem_wdata,     x_wdata);
        chk("mem_be",        mem_be,        x_be);
        chk("mem_read",      mem_read,      rd && !timed_out);
        chk("mem_write",     mem_write,     wr && !timed_out);
        chk("core_complete", core_complete, (e_sel == 1) && e_done);
        chk("core_error",    core_error,    (e_sel == 1) && e_done && err);
        chk("sba_complete",  sba_complete,  (e_sel == 2) && e_done);
        chk("sba_error",     sba_error,     (e_sel == 2) && e_done && err);
        chk("core_rdata",    core_rdata,    mem_rdata);
        chk("sba_rdata",     sba_rdata,     mem_rdata);
        chk("owner",         dut.r_owner,   m_current);
    endtask

    task automatic sample();
        @(negedge clk);
        check_outputs();
    endtask

    // Clock edge: advance the model, then let inputs change 1 time unit later.
    task automatic advance();
        @(posedge clk);
        if (!rst_n) begin
            m_current = 0;
            m_waited  = 0;
            m_turn    = 2;
        end else begin
            if (e_done) m_turn = e_sel;
            if (e_busy && !e_done) begin
                m_current = e_sel;
                m_waited  = m_waited + 1;
            end else begin
                m_current = 0;
                m_waited  = 0;
            end
        end
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic idle_inputs();
        core_read = 0; core_write = 0; sba_read = 0; sba_write = 0;
        mem_complete = 0; mem_error = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        advance();
        rst_n = 1;
    endtask

    // One requester's random behaviour: hold until done, sometimes abort.
    task automatic rnd_side(input bit done_prev, inout logic rd, inout logic wr,
                            inout logic [AW-1:0] addr, inout logic [DW-1:0] wdata,
                            inout logic [BW-1:0] be);
        logic [1:0] rw;
        bit start;
        start = 0;
        if (rd | wr) begin
            if (done_prev) begin
                if ($urandom_range(0, 1) == 0) begin rd = 0; wr = 0; end
                else start = 1;
            end else if ($urandom_range(0, 39) == 0) begin
                rd = 0; wr = 0;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            start = 1;
        end
        if (start) begin
            rw    = 2'($urandom_range(1, 3));
            rd    = rw[0];
            wr    = rw[1];
            addr  = $urandom;
            wdata = $urandom;
            be    = BW'($urandom);
        end
    endtask

    initial begin
        core_addr = '0; core_wdata = '0; core_be = '0;
        sba_addr = '0; sba_wdata = '0; sba_be = '0;
        mem_rdata = '0;
        e_sel = 0; e_busy = 0; e_done = 0;
        idle_inputs();
        core_addr = 32'h0000_0044; core_be = 4'h3;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        m_current = 0; m_waited = 0; m_turn = 2;

        // Reset state: nothing asserted, memory port follows the core.
        sample();
        chk("rst_mem_read",  mem_read,  1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_core_cpl",  core_complete, 1'b0);
        chk("rst_sba_cpl",   sba_complete,  1'b0);
        chk("rst_mem_addr",  mem_addr,  32'h0000_0044);
        advance();
        rst_n = 1;

        // Single-cycle core read.
        core_read = 1; core_addr = 32'h100; mem_complete = 1; mem_rdata = 32'hDEADBEEF;
        sample();
        chk("t1_mem_read",   mem_read, 1'b1);
        chk("t1_core_cpl",   core_complete, 1'b1);
        chk("t1_core_rdata", core_rdata, 32'hDEADBEEF);
        advance();
        idle_inputs();
        sample();
        chk("t1_owner_none", dut.r_owner, 0);
        advance();

        // Tie after reset: core first, then SBA, then core again.
        do_reset();
        core_write = 1; core_addr = 32'h300; core_wdata = 32'h1234_5678; core_be = 4'hF;
        sba_read = 1; sba_addr = 32'h400; sba_be = 4'h1;
        for (int c = 1; c <= 2; c++) begin
            sample();
            chk("t2_core_addr", mem_addr, 32'h300);
            chk("t2_core_wr",   mem_write, 1'b1);
            advance();
        end
        mem_complete = 1;
        sample();
        chk("t2_core_cpl", core_complete, 1'b1);
        chk("t2_sba_idle", sba_complete, 1'b0);
        advance();
        core_write = 0;
        sample();
        chk("t2_sba_addr", mem_addr, 32'h400);
        chk("t2_sba_cpl",  sba_complete, 1'b1);
        advance();
        core_read = 1; sba_read = 1; mem_complete = 0;
        sample();
        chk("t2_tie_core", mem_addr, 32'h300);
        advance();
        mem_complete = 1;
        tick();
        idle_inputs();
        tick();

        // Lock: SBA owns for five wait states while the core asks.
        sba_write = 1; sba_addr = 32'h500;
        for (int c = 1; c <= 6; c++) begin
            if (c == 2) begin core_read = 1; core_addr = 32'h600; end
            if (c == 6) mem_complete = 1;
            sample();
            chk("t3_lock_addr", mem_addr, 32'h500);
            chk("t3_core_wait", core_complete, 1'b0);
            advance();
        end
        sba_write = 0;
        sample();
        chk("t3_core_addr", mem_addr, 32'h600);
        chk("t3_core_cpl",  core_complete, 1'b1);
        advance();
        idle_inputs();
        tick();

        // Abort: core drops its read; pending SBA takes over next cycle.
        core_read = 1; core_addr = 32'h200;
        tick();
        sba_read = 1; sba_addr = 32'h700;
        sample();
        chk("t4_locked", mem_addr, 32'h200);
        advance();
        core_read = 0;
        sample();
        chk("t4_no_cpl",   core_complete, 1'b0);
        chk("t4_no_read",  mem_read, 1'b0);
        advance();
        sample();
        chk("t4_owner",    dut.r_owner, 0);
        chk("t4_sba_addr", mem_addr, 32'h700);
        chk("t4_sba_read", mem_read, 1'b1);
        advance();
        mem_complete = 1;
        tick();
        idle_inputs();
        tick();

        // Watchdog, then watchdog coinciding with a real completion.
        for (int rep = 0; rep < 2; rep++) begin
            sba_write = 1; sba_addr = 32'h800;
            for (int c = 1; c < TO; c++) begin
                sample();
                chk("t5_wait_cpl", sba_complete, 1'b0);
                chk("t5_wait_wr",  mem_write, 1'b1);
                advance();
            end
            mem_complete = (rep == 1);
            sample();
            chk("t5_fire_cpl", sba_complete, 1'b1);
            chk("t5_fire_err", sba_error, (rep == 0));
            chk("t5_fire_wr",  mem_write, 1'b0);
            advance();
            idle_inputs();
            tick();
        end

        // Memory fault on a core read; SBA side stays quiet.
        core_read = 1; core_addr = 32'h900; mem_complete = 1; mem_error = 1;
        sample();
        chk("t6_core_cpl", core_complete, 1'b1);
        chk("t6_core_err", core_error, 1'b1);
        chk("t6_sba_cpl",  sba_complete, 1'b0);
        chk("t6_sba_err",  sba_error, 1'b0);
        advance();
        idle_inputs();
        tick();

        // Reset in the middle of a core transaction that keeps requesting.
        core_read = 1; core_addr = 32'hA00;
        tick();
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        sample();
        chk("t7_owner_rst", dut.r_owner, 0);
        chk("t7_reread",    mem_read, 1'b1);
        advance();
        idle_inputs();
        sample();
        chk("t7_idle_read", mem_read, 1'b0);
        advance();

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rnd_side(e_done && (e_sel == 1), core_read, core_write, core_addr, core_wdata, core_be);
            rnd_side(e_done && (e_sel == 2), sba_read, sba_write, sba_addr, sba_wdata, sba_be);
            mem_complete = ($urandom_range(0, 99) < 30);
            mem_error    = ($urandom_range(0, 3) == 0);
            mem_rdata    = $urandom;
            rst_n        = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
